mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).
- Sequences each access with a req/ready handshake to the memory and returns data to the winning requester.
- Drives per-stage stall signals into the pipeline's hazard/flush logic.
- Sits between Datapath stage registers and the memory model; the Controller consumes its stall outputs.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_arb_watchdog.sv | 29 ++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the IF/MEM memory port arbiter.
// Holds the FSM state and owner encodings and the bus-width defaults
// that the Datapath also uses.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_I = 2'd1,
        S_BUSY_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // On a tie, the requester that did not own the port last time wins.
    function automatic owner_e rr_pick(input owner_e last);
        return (last == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory view.
interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // fetch side
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;
    // load/store side
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    // memory side
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              err;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter.
// expire is high during the TIMEOUT_CYC-th consecutive active cycle;
// clear holds the count at zero (the arbiter drives it while idle).
module mem_arb_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic active,
    output logic expire
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] count;

    assign expire = enable & active & (count == CNT_W'(TIMEOUT_CYC - 1));

    // Count busy cycles, saturating at the expiry point.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && active && !expire) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between the IF and MEM stages.
// Each grant issues one registered mem_req, waits for mem_ready (or the
// watchdog), returns data with a one-cycle valid pulse, then spends one
// mandatory idle cycle before the next grant.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking; without
// it the data port always beats the fetch port.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam logic [1:0] IDLE   = S_IDLE;
    localparam logic [1:0] BUSY_I = S_BUSY_I;
    localparam logic [1:0] BUSY_D = S_BUSY_D;

    logic [1:0]        state;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              if_valid_q;
    logic              d_valid_q;
    logic              err_q;

    logic i_elig;
    logic d_elig;
    logic grant_i;
    logic grant_d;
    logic expire;

    // A request that is being retired this cycle must not be granted again.
    assign i_elig = bus.if_req & ~if_valid_q;
    assign d_elig = bus.d_req & ~d_valid_q;

`ifdef MEM_ARB_RR_EN
    owner_e last_owner;

    assign grant_d = d_elig & (~i_elig | (rr_pick(last_owner) == OWN_D));

    // Remember the most recent owner so a tie goes to the other requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner <= OWN_I;
        end else if (state == IDLE && grant_d) begin
            last_owner <= OWN_D;
        end else if (state == IDLE && grant_i) begin
            last_owner <= OWN_I;
        end
    end
`else
    assign grant_d = d_elig;
`endif

    assign grant_i = i_elig & ~grant_d;

    generate
        if (TIMEOUT_CYC > 0) begin : g_wd
            mem_arb_watchdog #(
                .TIMEOUT_CYC (TIMEOUT_CYC)
            ) u_wd (
                .clk    (clk),
                .rst    (rst),
                .clear  (state == IDLE),
                .enable (1'b1),
                .active (state != IDLE),
                .expire (expire)
            );
        end else begin : g_no_wd
            assign expire = 1'b0;
        end
    endgenerate

    // Grant / wait / retire sequencing; valid and err are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
            err_q      <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= BUSY_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (grant_i) begin
                        state       <= BUSY_I;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr;
                        mem_wdata_q <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (bus.mem_ready) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        if (state == BUSY_I) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_valid_q <= 1'b1;
                        end else begin
                            d_rdata_q <= bus.mem_rdata;
                            d_valid_q <= 1'b1;
                        end
                    end else if (expire) begin
                        // Abort: owner is released with its old rdata kept.
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (state == BUSY_I) begin
                            if_valid_q <= 1'b1;
                        end else begin
                            d_valid_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.err       = err_q;
    assign bus.if_stall  = bus.if_req & ~if_valid_q;
    assign bus.d_stall   = bus.d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter (watchdog set to 8 cycles).
// Requesters push the address they issue; a memory responder with random
// latency pushes the expected outcome; a negedge monitor checks grants,
// stability, completion timing and returned data against those queues.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NTR = 40;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    int mode = 0;               // 0 random latency, 1 never ready, 2 zero latency

    logic [31:0] i_q[$];
    logic [31:0] d_q[$];
    int          len_q[$];
    bit          to_q[$];
    logic [31:0] last_i = '0;
    logic [31:0] last_d = '0;
    bit          tb_last_d = 1'b0;

    // monitor history
    logic        p_iel = 0, p_del = 0, p_req = 0, p_rst = 1, p_we = 0, p_dwe = 0;
    logic [31:0] p_ia = 0, p_da = 0, p_dwd = 0, p_addr = 0, p_wd = 0;
    logic        m_iel, m_del, exp_d, cur_d = 0;
    int          blen = 0;
    int          elen;
    bit          eto;
    logic [31:0] ma, mev;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=missing required=present t=%0t", name, $time);
    endtask

    task automatic req_i(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.if_addr = {1'b0, 29'($urandom()), 2'b00};
            bus.if_req  = 1'b1;
            i_q.push_back(bus.if_addr);
            t = 0;
            while (1) begin
                @(posedge clk); #1; t++;
                if (bus.if_valid) break;
                if (bus.mem_req && !bus.mem_addr[31] && $urandom_range(0, 7) == 0) bus.if_req = 1'b0;
                if (t > 200) begin
                    chk("i_wait_timeout", 64'(t), 64'd200);
                    break;
                end
            end
            bus.if_req = 1'b0;
        end
    endtask

    task automatic req_d(input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.d_addr  = {1'b1, 29'($urandom()), 2'b00};
            bus.d_we    = 1'($urandom_range(0, 1));
            bus.d_wdata = $urandom();
            bus.d_req   = 1'b1;
            d_q.push_back(bus.d_addr);
            t = 0;
            while (1) begin
                @(posedge clk); #1; t++;
                if (bus.d_valid) break;
                if (bus.mem_req && bus.mem_addr[31] && $urandom_range(0, 7) == 0) bus.d_req = 1'b0;
                if (t > 200) begin
                    chk("d_wait_timeout", 64'(t), 64'd200);
                    break;
                end
            end
            bus.d_req = 1'b0;
        end
    endtask

    // memory model: random latency per access, spurious ready while idle
    initial begin : responder
        int  bcnt;
        int  lat;
        int  r;
        logic pr;
        bcnt = 0; lat = 0; pr = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.mem_req && !pr) begin
                r = $urandom_range(0, 9);
                if (r <= 4)      lat = r;
                else if (r <= 6) lat = r - 5;
                else if (r == 7) lat = TO - 1;
                else if (r == 8) lat = TO;
                else             lat = 1000;
                if (mode == 1) lat = 1000;
                if (mode == 2) lat = 0;
                to_q.push_back(lat >= TO);
                len_q.push_back((lat >= TO) ? TO : lat + 1);
                bcnt = 0;
            end
            if (bus.mem_req) begin
                bus.mem_ready = (bcnt == lat);
                bus.mem_rdata = (bcnt == lat) ? hash(bus.mem_addr) : $urandom();
                bcnt++;
            end else begin
                bus.mem_ready = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom();
            end
            pr = bus.mem_req;
        end
    end

    // scoreboard monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            m_iel = bus.if_req & ~bus.if_valid;
            m_del = bus.d_req & ~bus.d_valid;
            if (mon_en && !rst && !p_rst) begin
                chk("if_stall", bus.if_stall, m_iel);
                chk("d_stall", bus.d_stall, m_del);
                if (!p_req) begin
                    if (p_iel || p_del) begin
`ifdef MEM_ARB_RR_EN
                        exp_d = p_del && (!p_iel || !tb_last_d);
`else
                        exp_d = p_del;
`endif
                        chk("grant_req", bus.mem_req, 1'b1);
                        chk("grant_owner", bus.mem_addr[31], exp_d);
                        if (exp_d) begin
                            chk("grant_d_we", bus.mem_we, p_dwe);
                            chk("grant_d_addr", bus.mem_addr, p_da);
                            chk("grant_d_wdata", bus.mem_wdata, p_dwd);
                        end else begin
                            chk("grant_i_we", bus.mem_we, 1'b0);
                            chk("grant_i_addr", bus.mem_addr, p_ia);
                        end
                        cur_d = exp_d;
                        tb_last_d = exp_d;
                        blen = 0;
                    end else begin
                        chk("idle_no_grant", bus.mem_req, 1'b0);
                    end
                end else if (bus.mem_req) begin
                    chk("hold_we", bus.mem_we, p_we);
                    chk("hold_addr", bus.mem_addr, p_addr);
                    chk("hold_wdata", bus.mem_wdata, p_wd);
                end
                if (bus.mem_req) blen++;
                if (p_req && !bus.mem_req) begin
                    if (len_q.size() == 0) begin
                        fail("outcome_queue");
                    end else begin
                        elen = len_q.pop_front();
                        eto  = to_q.pop_front();
                        chk("err_pulse", bus.err, eto);
                        chk("busy_len", 64'(blen), 64'(elen));
                        chk("if_valid_done", bus.if_valid, !cur_d);
                        chk("d_valid_done", bus.d_valid, cur_d);
                        if (cur_d) begin
                            if (d_q.size() == 0) fail("d_queue");
                            else begin
                                ma  = d_q.pop_front();
                                mev = eto ? last_d : hash(ma);
                                chk("d_rdata", bus.d_rdata, mev);
                                last_d = mev;
                            end
                        end else begin
                            if (i_q.size() == 0) fail("i_queue");
                            else begin
                                ma  = i_q.pop_front();
                                mev = eto ? last_i : hash(ma);
                                chk("if_rdata", bus.if_rdata, mev);
                                last_i = mev;
                            end
                        end
                    end
                end else begin
                    chk("no_spurious_pulse", {bus.if_valid, bus.d_valid, bus.err}, 3'b000);
                end
            end
            p_iel  = m_iel;
            p_del  = m_del;
            p_req  = bus.mem_req;
            p_rst  = rst;
            p_we   = bus.mem_we;
            p_addr = bus.mem_addr;
            p_wd   = bus.mem_wdata;
            p_ia   = bus.if_addr;
            p_da   = bus.d_addr;
            p_dwe  = bus.d_we;
            p_dwd  = bus.d_wdata;
        end
    end

    initial begin : main
        int t;
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_d_valid", bus.d_valid, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        fork
            req_i(NTR);
            req_d(NTR);
        join
        repeat (3) @(posedge clk);
        #1;

        // reset in the middle of a fetch, then a fresh fetch
        mon_en = 1'b0;
        mode = 1;
        bus.if_addr = 32'h10;
        bus.if_req  = 1'b1;
        t = 0;
        while (!bus.mem_req && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("midrst_grant", bus.mem_req, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_mem_req", bus.mem_req, 1'b0);
        chk("midrst_if_valid", bus.if_valid, 1'b0);
        chk("midrst_err", bus.err, 1'b0);
        mode = 2;
        @(posedge clk); #1;
        chk("postrst_mem_req", bus.mem_req, 1'b1);
        chk("postrst_mem_addr", bus.mem_addr, 32'h10);
        chk("postrst_mem_we", bus.mem_we, 1'b0);
        @(posedge clk); #1;
        chk("postrst_if_valid", bus.if_valid, 1'b1);
        chk("postrst_if_rdata", bus.if_rdata, hash(32'h10));
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        chk("postrst_valid_pulse", bus.if_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        i_q.delete(); d_q.delete(); len_q.delete(); to_q.delete();
        last_i = hash(32'h10);
        last_d = '0;
        tb_last_d = 1'b0;
        mode = 0;
        mon_en = 1'b1;

        fork
            req_i(NTR);
            req_d(NTR);
        join
        repeat (4) @(posedge clk);
        #1;
        chk("i_q_drained", 64'(i_q.size()), 64'd0);
        chk("d_q_drained", 64'(d_q.size()), 64'd0);
        chk("end_idle", bus.mem_req, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
